sha3_digest_serializer: RTL
===========================

SHA3_DIGEST_SERIALIZER -- requirements
Module: sha3_digest_serializer

Interface
REQ-001 Parameter OUT_W, default 16: output word width in bits; legal values 8, 16 or 32.
REQ-002 ACLK  in  1  single clock; all state changes on rising edge.
REQ-003 ARESET  in  1  reset, synchronous and active-high.
REQ-004 s_valid  in  1  Keccak state on s_state is final and valid.
REQ-005 s_ready  out  1  serializer can capture a new state.
REQ-006 s_state  in  [4:0][4:0][63:0]  permuted state from the Keccak core; s_state[x][y] is lane x+5*y.
REQ-007 s_mode  in  2  digest size: 00=224, 01=256, 10=384, 11=512 bits.
REQ-008 s_id  in  2  stream tag, passed through to m_id.
REQ-009 m_data  out  OUT_W  digest word.
REQ-010 m_valid  out  1  m_data is valid.
REQ-011 m_ready  in  1  downstream accepts m_data.
REQ-012 m_last  out  1  m_data is the final word of the digest.
REQ-013 m_id  out  2  tag captured with the current digest.
REQ-014 busy  out  1  high while in state SEND.

Function
REQ-015 FSM states: IDLE and SEND; no other states.
REQ-016 s_ready = 1 exactly when state is IDLE and ARESET is low; it is combinational from state.
REQ-017 In IDLE, s_valid=1 captures the lowest 512 digest bits, s_mode and s_id into registers, clears the word counter and enters SEND on the same edge.
REQ-018 Digest bit j = bit (j mod 64) of lane (j div 64), where lane i = s_state[i mod 5][i div 5].
REQ-019 Word k = digest bits [k*OUT_W+OUT_W-1 : k*OUT_W]; the first digest byte is in m_data[7:0].
REQ-020 Word count N = digest_bits/OUT_W (224/16=14, 256/16=16, 384/16=24, 512/16=32 at default); N is fixed at capture.
REQ-021 m_valid rises on the cycle after capture, giving a latency of 1 cycle from s_valid&s_ready to the first word.
REQ-022 In SEND, m_valid = 1 continuously; a word transfers on a cycle where m_valid & m_ready.
REQ-023 m_data, m_last and m_id hold stable while m_valid=1 and m_ready=0.
REQ-024 Each transfer increments the word counter; m_last = 1 exactly when counter = N-1.
REQ-025 Transfer of the last word returns the FSM to IDLE; m_valid is 0 and s_ready is 1 on the next cycle, so there is one idle cycle between digests.
REQ-026 s_valid during SEND is ignored; the captured state and mode are not disturbed.
REQ-027 s_mode and s_state changes after capture have no effect on the digest in flight.
REQ-028 Counter width is 6 bits; the counter never wraps, because it leaves SEND at N-1 (N max 64 for OUT_W=8).
REQ-029 m_data = 0 whenever m_valid = 0.

Reset
REQ-030 While ARESET=1 on an edge: state goes to IDLE, counter 0, m_valid 0, m_last 0, m_data 0, m_id 0, busy 0; s_ready is 0 during the reset cycle.
REQ-031 Reset mid-digest aborts the digest with no m_last; m_valid is 0 on the cycle after the reset edge, and s_ready is 1 on the first cycle with ARESET low.
REQ-032 Reset takes priority over a simultaneous s_valid or m_ready; nothing is captured or transferred.

Verification
REQ-033 Mode 01, lane0=64'h0123456789ABCDEF, m_ready=1 -> words 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123, ...; 16 words; m_last only on word 15; s_ready=1 one cycle after.
REQ-034 Mode 00, lane3=64'hFEDCBA9876543210 -> 14 words; word 13 = 16'h7654 with m_last=1; word 12 = 16'h3210.
REQ-035 Mode 11, lane7=64'hAAAA_BBBB_CCCC_DDDD -> 32 words; word 31 = 16'hAAAA with m_last=1; mode 10 -> 24 words.
REQ-036 Hold m_ready=0 for 3 cycles at word 5 -> m_data, m_last and m_id stay constant; the counter resumes at word 5; the total stays N with no duplicates or drops.
REQ-037 Pulse s_valid with a different state during SEND -> s_ready=0 and the output stream is unchanged; a second s_valid in IDLE with s_id=2'b10 -> m_id=2'b10 for all words.
REQ-038 Assert ARESET for 1 cycle at word 7 of a mode 01 digest -> m_valid=0 and busy=0 on the next cycle with no m_last seen; a new digest then starts cleanly at word 0.

Source files
------------

// File: rtl/sha3_digest_serializer_if.sv
// Handshake bundle between the Keccak core, the digest serializer and the downstream sink.
// The slave modport is the serializer's view; master is the environment driving it.
interface sha3_digest_serializer_if #(
    parameter int OUT_W = 16
);
    logic                   s_valid;
    logic                   s_ready;
    logic [4:0][4:0][63:0]  s_state;
    logic [1:0]             s_mode;
    logic [1:0]             s_id;
    logic [OUT_W-1:0]       m_data;
    logic                   m_valid;
    logic                   m_ready;
    logic                   m_last;
    logic [1:0]             m_id;

    modport slave (
        input  s_valid, s_state, s_mode, s_id, m_ready,
        output s_ready, m_data, m_valid, m_last, m_id
    );

    modport master (
        output s_valid, s_state, s_mode, s_id, m_ready,
        input  s_ready, m_data, m_valid, m_last, m_id
    );
endinterface

// File: rtl/sha3_digest_serializer.sv
// Captures the low 512 bits of a permuted Keccak state and streams the selected
// SHA-3 digest out as OUT_W-bit words, first digest byte in the low bits.
module sha3_digest_serializer #(
    parameter int OUT_W = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    sha3_digest_serializer_if.slave        bus,
    output logic                           busy
);
    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [5:0] LAST_224 = 6'(224 / OUT_W - 1);
    localparam logic [5:0] LAST_256 = 6'(256 / OUT_W - 1);
    localparam logic [5:0] LAST_384 = 6'(384 / OUT_W - 1);
    localparam logic [5:0] LAST_512 = 6'(512 / OUT_W - 1);

    state_e       state_q, state_d;
    logic [511:0] digest_q, digest_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [5:0]   last_idx_q, last_idx_d;
    logic [1:0]   id_q, id_d;
    logic [8:0]   bit_base;
    logic         capture, xfer, at_last;

    assign capture = (state_q == IDLE) && bus.s_valid;
    assign xfer    = (state_q == SEND) && bus.m_ready;
    assign at_last = (cnt_q == last_idx_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.s_valid) state_d = SEND;
            SEND:    if (bus.m_ready && at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_base    = 9'(cnt_q) * 9'(OUT_W);
        bus.s_ready = (state_q == IDLE) && !ARESET;
        bus.m_valid = (state_q == SEND);
        bus.m_last  = (state_q == SEND) && at_last;
        bus.m_data  = (state_q == SEND) ? digest_q[bit_base +: OUT_W] : '0;
        bus.m_id    = id_q;
        busy        = (state_q == SEND);
    end

    // Lane i lives at s_state[i mod 5][i div 5]; lanes 0..7 hold the largest digest.
    always_comb begin
        digest_d   = digest_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        id_d       = id_q;
        if (capture) begin
            digest_d = {bus.s_state[2][1], bus.s_state[1][1], bus.s_state[0][1],
                        bus.s_state[4][0], bus.s_state[3][0], bus.s_state[2][0],
                        bus.s_state[1][0], bus.s_state[0][0]};
            cnt_d    = '0;
            id_d     = bus.s_id;
            case (bus.s_mode)
                2'b00:   last_idx_d = LAST_224;
                2'b01:   last_idx_d = LAST_256;
                2'b10:   last_idx_d = LAST_384;
                default: last_idx_d = LAST_512;
            endcase
        end else if (xfer && !at_last) begin
            cnt_d = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cnt_q      <= '0;
            last_idx_q <= '0;
            id_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            id_q       <= id_d;
        end
    end

    // NOTE: the digest buffer is deliberately not reset; m_data is forced to zero outside SEND.
    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            digest_q <= digest_d;
        end
    end
endmodule
